str_lane_pipe: RTL and testbench

- Parametrised successor to the per-bit registered bank.
- Carries NUM_LANES lanes of LANE_WIDTH bits each through an elastic pipeline DEPTH stages deep.
- Uses a valid/ready handshake.
- A per-lane write-enable merge keeps the last accepted value in any lane that is not enabled.
- Sits between a streaming producer and consumer wherever the design needs multi-lane retiming with backpressure.
- All per-lane and per-stage replication is done with labelled generate blocks.

---
 rtl/str_lane_pipe_pkg.sv | 14 +
 rtl/str_lane_pipe_stage.sv | 43 ++++
 rtl/str_lane_pipe.sv | 110 +++++++++++
 tb/tb_str_lane_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/str_lane_pipe_pkg.sv
// Shared defaults and helpers for the multi-lane elastic pipeline.
// The occupancy counter width is derived here so every user sizes it the same way.
package str_lane_pipe_pkg;

    localparam int DEFAULT_NUM_LANES  = 8;
    localparam int DEFAULT_LANE_WIDTH = 1;
    localparam int DEFAULT_DEPTH      = 2;

    // Counter must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/str_lane_pipe_stage.sv
// One pipeline stage: a valid flag plus a data word, with load/clear controls.
// Load wins over clear, so a stage that hands its word on while refilling stays valid.
module str_lane_pipe_stage
    import str_lane_pipe_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_FILL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    // Data keeps its last value when the stage empties, so it never goes X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= RESET_FILL;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/str_lane_pipe.sv
// Multi-lane elastic retiming pipeline with valid/ready handshake and per-lane
// write-enable merge against the last accepted word. Bubbles collapse; no skid buffer.
module str_lane_pipe
    import str_lane_pipe_pkg::*;
#(
    parameter int                    NUM_LANES  = DEFAULT_NUM_LANES,
    parameter int                    LANE_WIDTH = DEFAULT_LANE_WIDTH,
    parameter int                    DEPTH      = DEFAULT_DEPTH,
    parameter logic [LANE_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] in_data,
    input  logic [NUM_LANES-1:0]            in_lane_en,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES*LANE_WIDTH-1:0] out_data,
    output logic [occ_width(DEPTH)-1:0]     occupancy
);

    localparam int               W          = NUM_LANES * LANE_WIDTH;
    localparam int               OCC_W      = occ_width(DEPTH);
    localparam logic [W-1:0]     RESET_WORD = {NUM_LANES{RESET_VAL}};

    logic [DEPTH-1:0]          w_valid;
    logic [DEPTH-1:0]          w_adv;
    logic [DEPTH-1:0]          w_load;
    logic [DEPTH-1:0][W-1:0]   w_din;
    logic [DEPTH-1:0][W-1:0]   w_stage_data;
    logic [W-1:0]              w_merged;
    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_drain;
    logic [OCC_W-1:0]          r_occ;

    // Advance resolves from the output end backwards so each stage sees its successor.
    always_comb begin
        w_adv = '0;
        w_adv[DEPTH-1] = w_valid[DEPTH-1] & out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            w_adv[k] = w_valid[k] & (~w_valid[k+1] | w_adv[k+1]);
        end
    end

    assign w_in_ready = ~w_valid[0] | w_adv[0];
    assign w_accept   = in_valid & w_in_ready;
    assign w_drain    = w_adv[DEPTH-1];

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : gen_lanes
            logic [LANE_WIDTH-1:0] r_hold;
            logic [LANE_WIDTH-1:0] w_lane_in;

            assign w_lane_in = in_data[i*LANE_WIDTH +: LANE_WIDTH];
            assign w_merged[i*LANE_WIDTH +: LANE_WIDTH] = in_lane_en[i] ? w_lane_in : r_hold;

            // Disabled lanes would reload their own value, so only enabled lanes need a write.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_hold <= RESET_VAL;
                end else if (w_accept && in_lane_en[i]) begin
                    r_hold <= w_lane_in;
                end
            end
        end
    endgenerate

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : gen_stages
            if (k == 0) begin : gen_head
                assign w_load[k] = w_accept;
                assign w_din[k]  = w_merged;
            end else begin : gen_body
                assign w_load[k] = w_adv[k-1];
                assign w_din[k]  = w_stage_data[k-1];
            end

            str_lane_pipe_stage #(
                .WIDTH      (W),
                .RESET_FILL (RESET_WORD)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_load[k]),
                .i_clear (w_adv[k]),
                .i_data  (w_din[k]),
                .o_valid (w_valid[k]),
                .o_data  (w_stage_data[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (w_accept && !w_drain) begin
            r_occ <= r_occ + 1'b1;
        end else if (!w_accept && w_drain) begin
            r_occ <= r_occ - 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_stage_data[DEPTH-1];
    assign occupancy = r_occ;

endmodule

// File: tb/tb_str_lane_pipe.sv
// Self-checking bench for str_lane_pipe (4 lanes x 8 bits, depth 3) against a
// queue-based reference: words in flight carry a position and pack toward the output.
module tb_str_lane_pipe;

    localparam int NL = 4;
    localparam int LW = 8;
    localparam int D  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [3:0]  in_lane_en = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    str_lane_pipe #(
        .NUM_LANES  (NL),
        .LANE_WIDTH (LW),
        .DEPTH      (D),
        .RESET_VAL  (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_lane_en (in_lane_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        int          pos;
    } ent_t;

    ent_t        m_q[$];
    logic [7:0]  m_hold[NL];
    logic [31:0] got[$];

    logic        s_rdy, s_ov;
    logic [31:0] s_d;
    logic [1:0]  s_occ;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [3:0]  en;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic        chk_d;
        logic [31:0] e_d;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        for (int i = 0; i < NL; i++) m_hold[i] = 8'h00;
    endtask

    // One clock cycle: drive, sample at negedge, compare with model, advance model at posedge.
    task automatic step(input logic iv, input logic [31:0] d, input logic [3:0] en, input logic ordy);
        logic        m_ov, m_rdy, acc, drn;
        logic [31:0] merged;
        ent_t        e;
        in_valid   = iv;
        in_data    = d;
        in_lane_en = en;
        out_ready  = ordy;
        @(negedge clk);
        s_rdy = in_ready;
        s_ov  = out_valid;
        s_d   = out_data;
        s_occ = occupancy;
        m_ov  = (m_q.size() > 0) && (m_q[0].pos == D - 1);
        m_rdy = (m_q.size() < D) || (m_ov && ordy);
        chk("in_ready", {31'b0, s_rdy}, {31'b0, m_rdy});
        chk("out_valid", {31'b0, s_ov}, {31'b0, m_ov});
        chk("occupancy", {30'b0, s_occ}, m_q.size());
        if (m_ov) chk("out_data", s_d, m_q[0].data);
        acc = iv && m_rdy;
        drn = m_ov && ordy;
        if (s_ov && ordy) got.push_back(s_d);
        @(posedge clk);
        if (drn) void'(m_q.pop_front());
        for (int i = 0; i < m_q.size(); i++) begin
            int lim;
            lim = D - 1 - i;
            m_q[i].pos = (m_q[i].pos + 1 < lim) ? m_q[i].pos + 1 : lim;
        end
        if (acc) begin
            for (int i = 0; i < NL; i++) begin
                if (en[i]) m_hold[i] = d[i*LW +: LW];
                merged[i*LW +: LW] = m_hold[i];
            end
            e.data = merged;
            e.pos  = 0;
            m_q.push_back(e);
        end
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 32'h11111111, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0};
        tbl[1] = '{1'b1, 32'h22222222, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        2'd1};
        tbl[2] = '{1'b1, 32'h33333333, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        2'd2};
        tbl[3] = '{1'b1, 32'h44444444, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11111111, 2'd3};
        tbl[4] = '{1'b1, 32'h44444444, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11111111, 2'd3};
        tbl[5] = '{1'b1, 32'h44444444, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 32'h11111111, 2'd3};
        tbl[6] = '{1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h22222222, 2'd3};
        tbl[7] = '{1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h33333333, 2'd2};
        tbl[8] = '{1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44444444, 2'd1};
        tbl[9] = '{1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0};

        // Reset state while rst is held.
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_occupancy", {30'b0, occupancy}, 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        do_reset();

        // Streaming: three words back to back, each out three cycles after accept.
        begin
            logic [31:0] w[3];
            logic [1:0]  peak;
            w[0] = 32'h03020100; w[1] = 32'h07060504; w[2] = 32'h0B0A0908;
            peak = 2'd0;
            for (int c = 0; c < 7; c++) begin
                step(c < 3, (c < 3) ? w[c % 3] : 32'h0, 4'hF, 1'b1);
                if (s_occ > peak) peak = s_occ;
                if (c >= 3 && c < 6) begin
                    chk("stream_valid", {31'b0, s_ov}, 32'd1);
                    chk("stream_data", s_d, w[c-3]);
                end else begin
                    chk("stream_idle", {31'b0, s_ov}, 32'd0);
                end
            end
            chk("stream_peak_occ", {30'b0, peak}, 32'd3);
        end

        // Lane merge against the held word.
        got.delete();
        step(1'b1, 32'hAABBCCDD, 4'hF, 1'b1);
        step(1'b1, 32'h11223344, 4'b0101, 1'b1);
        for (int c = 0; c < 5; c++) step(1'b0, 32'h0, 4'h0, 1'b1);
        chk("merge_count", got.size(), 32'd2);
        if (got.size() == 2) begin
            chk("merge_first", got[0], 32'hAABBCCDD);
            chk("merge_second", got[1], 32'hAA22CC44);
        end

        // Backpressure table.
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].en, tbl[i].ordy);
            chk("tbl_in_ready", {31'b0, s_rdy}, {31'b0, tbl[i].e_rdy});
            chk("tbl_out_valid", {31'b0, s_ov}, {31'b0, tbl[i].e_ov});
            chk("tbl_occupancy", {30'b0, s_occ}, {30'b0, tbl[i].e_occ});
            if (tbl[i].chk_d) chk("tbl_out_data", s_d, tbl[i].e_d);
        end

        // Bubble collapse: lone word travels to the last stage with the consumer stalled.
        do_reset();
        step(1'b1, 32'hDEADBEEF, 4'hF, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, 32'h0, 4'h0, 1'b0);
        chk("bubble_out_valid", {31'b0, s_ov}, 32'd1);
        chk("bubble_occupancy", {30'b0, s_occ}, 32'd1);
        chk("bubble_in_ready", {31'b0, s_rdy}, 32'd1);
        chk("bubble_data", s_d, 32'hDEADBEEF);

        // Asynchronous reset mid-stream, away from any clock edge.
        do_reset();
        step(1'b1, 32'h55555555, 4'hF, 1'b0);
        step(1'b1, 32'h66666666, 4'hF, 1'b0);
        chk("pre_rst_occ", {30'b0, occupancy}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_occupancy", {30'b0, occupancy}, 32'd0);
        chk("async_rst_out_data", out_data, 32'h0);
        do_reset();
        got.delete();
        step(1'b1, 32'h000000FF, 4'b0001, 1'b1);
        for (int c = 0; c < 4; c++) step(1'b0, 32'h0, 4'h0, 1'b1);
        chk("post_rst_count", got.size(), 32'd1);
        if (got.size() == 1) chk("post_rst_data", got[0], 32'h000000FF);

        // Full pipe with simultaneous accept and drain.
        do_reset();
        got.delete();
        for (int c = 0; c < 3; c++) step(1'b1, 32'h0 + c + 1, 4'hF, 1'b0);
        for (int c = 3; c < 7; c++) begin
            step(1'b1, 32'h0 + c + 1, 4'hF, 1'b1);
            chk("full_flow_occ", {30'b0, s_occ}, 32'd3);
        end
        for (int c = 0; c < 5; c++) step(1'b0, 32'h0, 4'h0, 1'b1);
        chk("full_flow_count", got.size(), 32'd7);
        for (int i = 0; i < got.size() && i < 7; i++) chk("full_flow_order", got[i], i + 1);

        // Randomised traffic against the reference.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step(($urandom % 4) != 0, $urandom, 4'($urandom), ($urandom % 3) != 0);
        end
        for (int c = 0; c < 6; c++) step(1'b0, 32'h0, 4'h0, 1'b1);
        chk("random_drained_occ", {30'b0, occupancy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
